passcode_controller: RTL and testbench
======================================

// Module: passcode_controller
// PURPOSE
//  Sequences keypad entry into the 4-bit digit registers of the security panel: steers each digit into
//  its entry register, compares the entry against the stored code registers, and grants or denies access.
//  Counts failures, enforces a timed lockout, and lets a granted user reprogram the stored code.
//  Sits between the keypad decoder and the digit register bank; unlock/alarm feed the actuator/alarm logic.
// PARAMETERS
//  DIGITS         4     digits per code (entry regs and code regs, 4 bits each)
//  MAX_FAIL       3     consecutive failures that trigger lockout
//  LOCK_CYCLES    1000  lockout duration, clk cycles
//  ENTRY_TIMEOUT  5000  idle cycles inside ENTRY before entry is abandoned
//  GRANT_CYCLES   50    cycles unlock stays high
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          reset, asynchronous, active-low
//  key_valid  in   1          one-cycle strobe: key_code holds a key
//  key_code   in   4          key value; 0-9 digits, 10-15 ignored
//  key_enter  in   1          one-cycle strobe: submit entry
//  key_clear  in   1          one-cycle strobe: discard entry
//  prog_req   in   1          request code reprogramming (honoured only in GRANT)
//  entry_q    in   4*DIGITS   Q of entry registers, digit i at [4i+3:4i]
//  code_q     in   4*DIGITS   Q of stored-code registers, same packing
//  reg_d      out  4          shared data bus to all digit registers
//  entry_en   out  DIGITS     one-hot load enable, entry registers
//  code_en    out  DIGITS     one-hot load enable, code registers
//  entry_clr  out  1          one-cycle clear pulse to entry registers (their active-high rst)
//  unlock     out  1          access granted, level
//  fail       out  1          one-cycle pulse per denied attempt
//  alarm      out  1          high throughout LOCKOUT
//  prog_done  out  1          one-cycle pulse: new code stored
//  digit_cnt  out  3          digits captured in current entry/program pass
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; fail counter 0; timer 0. All outputs registered.
//  - Input priority per cycle: key_clear > key_valid > key_enter; losers are dropped, not queued.
//  - Digit write: key_valid with digit key in IDLE/ENTRY and digit_cnt<DIGITS -> next cycle reg_d=key_code,
//    entry_en[digit_cnt]=1 for exactly one cycle, digit_cnt+1; IDLE->ENTRY. Keys 10-15 and digits beyond
//    DIGITS are ignored (no enable, no count).
//  - ENTRY: key_enter with digit_cnt==DIGITS -> CHECK; with digit_cnt<DIGITS -> DENY.
//    key_clear -> entry_clr pulse, digit_cnt=0, IDLE, no failure counted.
//    ENTRY_TIMEOUT cycles with no key strobe -> same as key_clear. Timer restarts on every strobe.
//  - CHECK (1 cycle): entry_q==code_q -> GRANT else DENY. Enter sampled at the cycle after the last
//    digit strobe is legal; entry_q is settled by CHECK.
//  - GRANT: unlock=1 for GRANT_CYCLES, fail counter cleared, entry_clr pulse on entry; then IDLE.
//    prog_req during GRANT -> PROGRAM (unlock drops next cycle).
//  - DENY (1 cycle): fail pulse, entry_clr pulse, fail counter+1 (saturating at MAX_FAIL);
//    counter==MAX_FAIL after increment -> LOCKOUT else IDLE.
//  - LOCKOUT: alarm=1 for LOCK_CYCLES; all key inputs ignored; on exit fail counter=0, IDLE.
//  - PROGRAM: digit keys drive reg_d/code_en[digit_cnt] as for entry; after DIGITS digits -> prog_done
//    pulse, digit_cnt=0, IDLE. key_clear or timeout aborts to IDLE; already written code digits stay
//    written (partial code is the caller's risk, documented). key_enter ignored.
//  - entry_en and code_en never both nonzero; at most one bit set.
//  - rst_n mid-operation: immediate IDLE, outputs 0; register contents not touched by this block.
// STRUCTURE
//  - security_pkg: state enum {IDLE,ENTRY,CHECK,GRANT,DENY,LOCKOUT,PROGRAM}, DIGIT_W=4, KEY_MAX_DIGIT=9.
//  - Sub-module sec_timer: loadable down-counter with done flag; one instance shared by timeout,
//    grant and lockout (only one active per state). Width from $clog2 of the largest count.
// TESTING (bench uses DIGITS=4, MAX_FAIL=3, LOCK_CYCLES=20, ENTRY_TIMEOUT=15, GRANT_CYCLES=5)
//  1 code_q=0x1234, keys 4,3,2,1, enter -> entry_en 0001,0010,0100,1000 with reg_d 4,3,2,1; unlock 5 cycles.
//  2 code_q=0x1234, enter 1,1,1,1 three times -> 3 fail pulses; alarm high 20 cycles; keys ignored meanwhile.
//  3 keys 1,2 then enter -> DENY, fail pulse, no CHECK; key 12 mid-entry -> no enable, digit_cnt unchanged.
//  4 two digits then 15 idle cycles -> entry_clr pulse, IDLE, fail counter unchanged.
//  5 GRANT + prog_req, keys 9,8,7,6 -> code_en one-hot sequence, prog_done pulse, no entry_en activity.
//  6 rst_n low during ENTRY and during LOCKOUT -> outputs 0 same cycle, IDLE; key_clear+key_valid same cycle -> clear wins.

Source files
------------

// File: rtl/security_pkg.sv
// Shared types and constants for the security panel passcode logic.
package security_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    GRANT,
    DENY,
    LOCKOUT,
    PROGRAM
  } sec_state_e;

  localparam int unsigned DIGIT_W       = 4;
  localparam logic [3:0]  KEY_MAX_DIGIT = 4'd9;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] key);
    return key <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module sec_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/passcode_controller.sv
// Keypad entry sequencer: steers digits into the entry/code register bank,
// checks the entry, grants or denies access, and enforces a failure lockout.
module passcode_controller
  import security_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCK_CYCLES   = 1000,
  parameter int unsigned ENTRY_TIMEOUT = 5000,
  parameter int unsigned GRANT_CYCLES  = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_code,
  input  logic                        key_enter,
  input  logic                        key_clear,
  input  logic                        prog_req,
  input  logic [DIGIT_W*DIGITS-1:0]   entry_q,
  input  logic [DIGIT_W*DIGITS-1:0]   code_q,
  output logic [DIGIT_W-1:0]          reg_d,
  output logic [DIGITS-1:0]           entry_en,
  output logic [DIGITS-1:0]           code_en,
  output logic                        entry_clr,
  output logic                        unlock,
  output logic                        fail,
  output logic                        alarm,
  output logic                        prog_done,
  output logic [2:0]                  digit_cnt
);

  localparam int unsigned TMR_MAX =
    (LOCK_CYCLES > ENTRY_TIMEOUT)
      ? ((LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES)
      : ((ENTRY_TIMEOUT > GRANT_CYCLES) ? ENTRY_TIMEOUT : GRANT_CYCLES);
  localparam int unsigned TMR_W  = $clog2(TMR_MAX + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  // Timer holds N-1 so the done cycle is the last of N cycles in the state.
  localparam logic [TMR_W-1:0]  T_ENTRY  = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  T_GRANT  = TMR_W'(GRANT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  T_LOCK   = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);
  localparam logic [2:0]        DIG_LIM  = 3'(DIGITS);

  sec_state_e          state, state_n;
  logic [FAIL_W-1:0]   fails, fails_n;
  logic [DIGIT_W-1:0]  reg_d_n;
  logic [DIGITS-1:0]   entry_en_n, code_en_n;
  logic                entry_clr_n, unlock_n, fail_n, alarm_n, prog_done_n;
  logic [2:0]          cnt_n;
  logic                tmr_load, tmr_done;
  logic [TMR_W-1:0]    tmr_val;
  logic                strobe, digit_ok, go_grant, go_deny;

  sec_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n     = state;
    fails_n     = fails;
    reg_d_n     = '0;
    entry_en_n  = '0;
    code_en_n   = '0;
    entry_clr_n = 1'b0;
    unlock_n    = 1'b0;
    fail_n      = 1'b0;
    alarm_n     = 1'b0;
    prog_done_n = 1'b0;
    cnt_n       = digit_cnt;
    tmr_load    = 1'b0;
    tmr_val     = T_ENTRY;
    go_grant    = 1'b0;
    go_deny     = 1'b0;
    strobe      = key_valid | key_enter | key_clear;
    digit_ok    = key_valid && is_digit(key_code) && (digit_cnt < DIG_LIM);

    case (state)
      IDLE: begin
        if (!key_clear && digit_ok) begin
          reg_d_n    = key_code;
          entry_en_n = DIGITS'(1) << digit_cnt;
          cnt_n      = digit_cnt + 3'd1;
          state_n    = ENTRY;
          tmr_load   = 1'b1;
        end
      end
      ENTRY: begin
        if (key_clear || (!strobe && tmr_done)) begin
          entry_clr_n = 1'b1;
          cnt_n       = '0;
          state_n     = IDLE;
        end else begin
          tmr_load = strobe;
          // A key_valid strobe suppresses enter even when the key itself is ignored.
          if (key_valid) begin
            if (digit_ok) begin
              reg_d_n    = key_code;
              entry_en_n = DIGITS'(1) << digit_cnt;
              cnt_n      = digit_cnt + 3'd1;
            end
          end else if (key_enter) begin
            if (digit_cnt == DIG_LIM) state_n = CHECK;
            else                      go_deny = 1'b1;
          end
        end
      end
      CHECK: begin
        if (entry_q == code_q) go_grant = 1'b1;
        else                   go_deny  = 1'b1;
      end
      GRANT: begin
        if (prog_req) begin
          state_n  = PROGRAM;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_n = IDLE;
        end else begin
          unlock_n = 1'b1;
        end
      end
      DENY: begin
        if (fails == FAIL_LIM) begin
          state_n  = LOCKOUT;
          alarm_n  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = T_LOCK;
        end else begin
          state_n = IDLE;
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          state_n = IDLE;
          fails_n = '0;
        end else begin
          alarm_n = 1'b1;
        end
      end
      PROGRAM: begin
        if (digit_cnt == DIG_LIM) begin
          prog_done_n = 1'b1;
          cnt_n       = '0;
          state_n     = IDLE;
        end else if (key_clear || (!strobe && tmr_done)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          tmr_load = strobe;
          if (digit_ok) begin
            reg_d_n   = key_code;
            code_en_n = DIGITS'(1) << digit_cnt;
            cnt_n     = digit_cnt + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (go_grant) begin
      state_n     = GRANT;
      unlock_n    = 1'b1;
      entry_clr_n = 1'b1;
      cnt_n       = '0;
      fails_n     = '0;
      tmr_load    = 1'b1;
      tmr_val     = T_GRANT;
    end
    if (go_deny) begin
      state_n     = DENY;
      fail_n      = 1'b1;
      entry_clr_n = 1'b1;
      cnt_n       = '0;
      fails_n     = (fails >= FAIL_LIM) ? fails : fails + FAIL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fails     <= '0;
      reg_d     <= '0;
      entry_en  <= '0;
      code_en   <= '0;
      entry_clr <= 1'b0;
      unlock    <= 1'b0;
      fail      <= 1'b0;
      alarm     <= 1'b0;
      prog_done <= 1'b0;
      digit_cnt <= '0;
    end else begin
      state     <= state_n;
      fails     <= fails_n;
      reg_d     <= reg_d_n;
      entry_en  <= entry_en_n;
      code_en   <= code_en_n;
      entry_clr <= entry_clr_n;
      unlock    <= unlock_n;
      fail      <= fail_n;
      alarm     <= alarm_n;
      prog_done <= prog_done_n;
      digit_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_passcode_controller.sv
// Directed and randomized checks of passcode_controller against a behavioural model.
module tb_passcode_controller;

  localparam int DIGITS        = 4;
  localparam int MAX_FAIL      = 3;
  localparam int LOCK_CYCLES   = 20;
  localparam int ENTRY_TIMEOUT = 15;
  localparam int GRANT_CYCLES  = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid, key_enter, key_clear, prog_req;
  logic [3:0]  key_code;
  logic [15:0] entry_q = '0;
  logic [15:0] code_q  = '0;
  logic [3:0]  reg_d;
  logic [3:0]  entry_en, code_en;
  logic        entry_clr, unlock, fail, alarm, prog_done;
  logic [2:0]  digit_cnt;

  logic        preload;
  logic [15:0] preload_val;

  int vectors = 0;
  int miscompares = 0;
  int fails_model = 0;
  logic [15:0] code_model;

  passcode_controller #(
    .DIGITS        (DIGITS),
    .MAX_FAIL      (MAX_FAIL),
    .LOCK_CYCLES   (LOCK_CYCLES),
    .ENTRY_TIMEOUT (ENTRY_TIMEOUT),
    .GRANT_CYCLES  (GRANT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .prog_req  (prog_req),
    .entry_q   (entry_q),
    .code_q    (code_q),
    .reg_d     (reg_d),
    .entry_en  (entry_en),
    .code_en   (code_en),
    .entry_clr (entry_clr),
    .unlock    (unlock),
    .fail      (fail),
    .alarm     (alarm),
    .prog_done (prog_done),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  // Digit register bank the controller drives.
  always @(posedge clk) begin
    if (preload) code_q <= preload_val;
    else for (int i = 0; i < DIGITS; i++) if (code_en[i]) code_q[4*i +: 4] <= reg_d;
    if (entry_clr) entry_q <= '0;
    else for (int i = 0; i < DIGITS; i++) if (entry_en[i]) entry_q[4*i +: 4] <= reg_d;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      assert ($countones({entry_en, code_en}) <= 1) else begin
        miscompares++;
        $error("FAIL onehot_en: observed entry_en=%b code_en=%b required at most one bit set", entry_en, code_en);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_code(input logic [15:0] v);
    preload_val = v; preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    code_model = v;
  endtask

  task automatic press(input logic [3:0] k);
    key_code = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter_digits(input logic [15:0] digs, input int n);
    for (int i = 0; i < n; i++) begin
      press(digs[4*i +: 4]);
      chk("entry_en", entry_en, 1 << i);
      chk("reg_d", reg_d, digs[4*i +: 4]);
      chk("digit_cnt", digit_cnt, i + 1);
    end
  endtask

  task automatic submit(input logic [15:0] digs, input int n, input bit do_prog);
    int lat, width;
    bit exp_grant;
    exp_grant = (n == DIGITS) && (digs == code_model);
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    lat = 1;
    while (!unlock && !fail && lat < 8) begin @(negedge clk); lat++; end
    chk("resp_latency", lat, (n == DIGITS) ? 2 : 1);
    chk("unlock", unlock, exp_grant);
    chk("fail", fail, !exp_grant);
    chk("entry_clr", entry_clr, 1);
    if (exp_grant) begin
      fails_model = 0;
      if (do_prog) return;
      width = 0;
      while (unlock && width < 100) begin width++; @(negedge clk); end
      chk("unlock_width", width, GRANT_CYCLES);
    end else begin
      fails_model = (fails_model + 1 > MAX_FAIL) ? MAX_FAIL : fails_model + 1;
      @(negedge clk);
      chk("fail_pulse", fail, 0);
      chk("alarm", alarm, fails_model == MAX_FAIL);
      if (fails_model == MAX_FAIL) begin
        width = 0;
        while (alarm && width < 200) begin
          width++;
          key_code  = 4'($urandom_range(15));
          key_valid = 1'($urandom_range(1));
          @(negedge clk);
          key_valid = 1'b0;
          chk("lock_ignore", {entry_en, digit_cnt}, 0);
        end
        chk("alarm_width", width, LOCK_CYCLES);
        fails_model = 0;
      end
    end
  endtask

  task automatic attempt(input logic [15:0] digs, input int n);
    enter_digits(digs, n);
    submit(digs, n, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    int n;
    rst_n = 1'b0; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    prog_req = 1'b0; key_code = '0; preload = 1'b0; preload_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {reg_d, entry_en, code_en, entry_clr, unlock, fail, alarm, prog_done, digit_cnt}, 0);
    rst_n = 1'b1;
    load_code(16'h1234);

    // 1: correct code entered as 4,3,2,1
    attempt(16'h1234, 4);
    // 2: three wrong entries -> lockout
    for (int r = 0; r < 3; r++) attempt(16'h1111, 4);
    // 3: short entry with an ignored key in the middle
    enter_digits(16'h0021, 2);
    press(4'd12);
    chk("key12_en", entry_en, 0);
    chk("key12_cnt", digit_cnt, 2);
    submit(16'h0021, 2, 1'b0);
    // 4: idle timeout mid-entry
    enter_digits(16'h0057, 2);
    for (int k = 1; k <= ENTRY_TIMEOUT; k++) begin
      @(negedge clk);
      if (k == ENTRY_TIMEOUT - 1) chk("timeout_early", entry_clr, 0);
    end
    chk("timeout_clr", entry_clr, 1);
    chk("timeout_cnt", digit_cnt, 0);
    chk("timeout_nofail", fail, 0);
    attempt(16'h0001, 1);
    attempt(16'h0002, 1);
    // 5: grant then reprogram to 9,8,7,6
    enter_digits(16'h1234, 4);
    submit(16'h1234, 4, 1'b1);
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
    chk("prog_unlock_drop", unlock, 0);
    d = 16'h6789;
    for (int i = 0; i < DIGITS; i++) begin
      press(d[4*i +: 4]);
      chk("code_en", code_en, 1 << i);
      chk("prog_entry_en", entry_en, 0);
      chk("prog_reg_d", reg_d, d[4*i +: 4]);
    end
    @(negedge clk);
    chk("prog_done", prog_done, 1);
    chk("prog_cnt", digit_cnt, 0);
    code_model = d;
    @(negedge clk);
    chk("prog_done_pulse", prog_done, 0);
    attempt(16'h6789, 4);
    attempt(16'h1234, 4);
    // 6: reset during ENTRY and during LOCKOUT; clear beats valid
    enter_digits(16'h0034, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_entry", {digit_cnt, entry_en, unlock, fail, alarm}, 0);
    fails_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    attempt(16'h0003, 1);
    attempt(16'h0004, 1);
    enter_digits(16'h0005, 1);
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    chk("deny3_fail", fail, 1);
    @(negedge clk);
    chk("deny3_alarm", alarm, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_lock_alarm", alarm, 0);
    chk("rst_lock_outs", {unlock, fail, entry_en, code_en, digit_cnt}, 0);
    fails_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    enter_digits(16'h0008, 1);
    key_clear = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk);
    key_clear = 1'b0; key_valid = 1'b0;
    chk("clr_wins_en", entry_en, 0);
    chk("clr_wins_clr", entry_clr, 1);
    chk("clr_wins_cnt", digit_cnt, 0);
    chk("clr_wins_fail", fail, 0);
    attempt(16'h6789, 4);

    // randomized attempts: random stored code, random length, often correct
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'($urandom_range(9));
      load_code(d);
      n = $urandom_range(1, DIGITS);
      if ($urandom_range(1) == 0)
        for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'($urandom_range(9));
      for (int i = n; i < DIGITS; i++) d[4*i +: 4] = 4'd0;
      attempt(d, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
